// File: rtl/serial_sub.sv
// Digit-serial subtractor: diff = a - b - bin, DIGIT bits per clock,
// with borrow chained through a register and a start/busy/done handshake.
module serial_sub #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf,
  output logic             zero
);

  localparam int STEPS = WIDTH / DIGIT;
  localparam int CW = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic             brw_q, brw_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             amsb_q, amsb_d;
  logic             bmsb_q, bmsb_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [DIGIT:0]   dig;
  logic [WIDTH-1:0] diff_sh;

  // One digit of the chain; the extra MSB is the outgoing borrow.
  assign dig = {1'b0, opa_q[DIGIT-1:0]}
             - {1'b0, opb_q[DIGIT-1:0]}
             - {{DIGIT{1'b0}}, brw_q};

  if (DIGIT == WIDTH) begin : g_one
    assign diff_sh = dig[DIGIT-1:0];
  end else begin : g_many
    assign diff_sh = {dig[DIGIT-1:0], diff_q[WIDTH-1:DIGIT]};
  end

  always_comb begin
    state_d = state_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    brw_d   = brw_q;
    cnt_d   = cnt_q;
    amsb_d  = amsb_q;
    bmsb_d  = bmsb_q;
    diff_d  = diff_q;
    bout_d  = bout_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          opa_d   = a;
          opb_d   = b;
          brw_d   = bin;
          amsb_d  = a[WIDTH-1];
          bmsb_d  = b[WIDTH-1];
          cnt_d   = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        diff_d = diff_sh;
        opa_d  = opa_q >> DIGIT;
        opb_d  = opb_q >> DIGIT;
        brw_d  = dig[DIGIT];
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = DONE;
          bout_d  = dig[DIGIT];
          ovf_d   = (amsb_q ^ bmsb_q)
                  & (diff_sh[WIDTH-1] ^ amsb_q);
          zero_d  = (diff_sh == '0);
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      opa_q   <= '0;
      opb_q   <= '0;
      brw_q   <= 1'b0;
      cnt_q   <= '0;
      amsb_q  <= 1'b0;
      bmsb_q  <= 1'b0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      brw_q   <= brw_d;
      cnt_q   <= cnt_d;
      amsb_q  <= amsb_d;
      bmsb_q  <= bmsb_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign diff = diff_q;
  assign bout = bout_q;
  assign ovf  = ovf_q;
  assign zero = zero_q;

endmodule

// File: tb/tb_serial_sub.sv
// Bench for serial_sub in 16/4, 1/1 and 8/8 configurations,
// checked against an arithmetic model of a - b - bin.
module tb_serial_sub;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic        s16, bi16, busy16, done16, bo16, ov16, z16;
  logic [15:0] a16, b16, d16;
  logic        s1, bi1, busy1, done1, bo1, ov1, z1;
  logic [0:0]  a1, b1, d1;
  logic        s8, bi8, busy8, done8, bo8, ov8, z8;
  logic [7:0]  a8, b8, d8;

  int n_chk = 0;
  int n_pass = 0;

  serial_sub #(.WIDTH(16), .DIGIT(4)) u16 (
    .clk(clk), .rst_n(rst_n), .start(s16), .a(a16), .b(b16),
    .bin(bi16), .busy(busy16), .done(done16), .diff(d16),
    .bout(bo16), .ovf(ov16), .zero(z16));

  serial_sub #(.WIDTH(1), .DIGIT(1)) u1 (
    .clk(clk), .rst_n(rst_n), .start(s1), .a(a1), .b(b1),
    .bin(bi1), .busy(busy1), .done(done1), .diff(d1),
    .bout(bo1), .ovf(ov1), .zero(z1));

  serial_sub #(.WIDTH(8), .DIGIT(8)) u8 (
    .clk(clk), .rst_n(rst_n), .start(s8), .a(a8), .b(b8),
    .bin(bi8), .busy(busy8), .done(done8), .diff(d8),
    .bout(bo8), .ovf(ov8), .zero(z8));

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Plain integer arithmetic: unsigned and signed views of a - b - bin.
  function automatic void model(input int w, input longint ua,
      input longint ub, input longint ubin, output longint d,
      output bit bo, output bit ov, output bit z);
    longint m, r, sa, sb, sr;
    m  = longint'(1) << w;
    r  = ua - ub - ubin;
    bo = (r < 0);
    d  = (r + m) % m;
    sa = (ua >= m / 2) ? ua - m : ua;
    sb = (ub >= m / 2) ? ub - m : ub;
    sr = sa - sb - ubin;
    ov = (sr < -(m / 2)) || (sr > m / 2 - 1);
    z  = (d == 0);
  endfunction

  task automatic check16(input logic [15:0] ta, input logic [15:0] tb,
                         input logic tbin);
    longint ed;
    bit eb, eo, ez;
    model(16, longint'(ta), longint'(tb), longint'(tbin), ed, eb, eo, ez);
    chk("done16", done16, 1);
    chk("busy16_off", busy16, 0);
    chk("diff16", d16, 32'(ed));
    chk("bout16", bo16, 32'(eb));
    chk("ovf16", ov16, 32'(eo));
    chk("zero16", z16, 32'(ez));
  endtask

  task automatic op16(input logic [15:0] ta, input logic [15:0] tb,
                      input logic tbin);
    @(negedge clk);
    s16 = 1'b1; a16 = ta; b16 = tb; bi16 = tbin;
    @(negedge clk);
    s16 = 1'b0; a16 = 16'($urandom); b16 = 16'($urandom);
    bi16 = 1'($urandom);
    for (int i = 0; i < 4; i++) begin
      chk("busy16", busy16, 1);
      chk("nodone16", done16, 0);
      @(negedge clk);
    end
    check16(ta, tb, tbin);
  endtask

  task automatic op1(input logic ta, input logic tb, input logic tbin);
    longint ed;
    bit eb, eo, ez;
    model(1, longint'(ta), longint'(tb), longint'(tbin), ed, eb, eo, ez);
    @(negedge clk);
    s1 = 1'b1; a1 = ta; b1 = tb; bi1 = tbin;
    @(negedge clk);
    s1 = 1'b0; a1 = ~ta; b1 = ~tb; bi1 = ~tbin;
    chk("busy1", busy1, 1);
    @(negedge clk);
    chk("done1", done1, 1);
    chk("diff1", d1, 32'(ed));
    chk("bout1", bo1, 32'(eb));
    chk("ovf1", ov1, 32'(eo));
  endtask

  task automatic op8(input logic [7:0] ta, input logic [7:0] tb,
                     input logic tbin);
    longint ed;
    bit eb, eo, ez;
    model(8, longint'(ta), longint'(tb), longint'(tbin), ed, eb, eo, ez);
    @(negedge clk);
    s8 = 1'b1; a8 = ta; b8 = tb; bi8 = tbin;
    @(negedge clk);
    s8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
    chk("busy8", busy8, 1);
    @(negedge clk);
    chk("done8", done8, 1);
    chk("diff8", d8, 32'(ed));
    chk("bout8", bo8, 32'(eb));
    chk("ovf8", ov8, 32'(eo));
    chk("zero8", z8, 32'(ez));
  endtask

  initial begin
    rst_n = 1'b0;
    s16 = 0; a16 = 0; b16 = 0; bi16 = 0;
    s1 = 0; a1 = 0; b1 = 0; bi1 = 0;
    s8 = 0; a8 = 0; b8 = 0; bi8 = 0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy16, 0);
    chk("rst_done", done16, 0);
    chk("rst_diff", d16, 0);
    chk("rst_flags", {bo16, ov16, z16}, 0);
    rst_n = 1'b1;

    op16(16'h1234, 16'h0234, 1'b0);
    op16(16'h0000, 16'h0001, 1'b0);
    op16(16'h8000, 16'h0001, 1'b0);
    op16(16'h0005, 16'h0004, 1'b1);
    op16(16'h7FFF, 16'hFFFF, 1'b0);
    op16(16'hFFFF, 16'hFFFF, 1'b1);

    // start during busy is ignored
    @(negedge clk);
    s16 = 1'b1; a16 = 16'h1234; b16 = 16'h0234; bi16 = 1'b0;
    @(negedge clk);
    s16 = 1'b0;
    @(negedge clk);
    s16 = 1'b1; a16 = 16'hFFFF; b16 = 16'h0000;
    @(negedge clk);
    s16 = 1'b0;
    @(negedge clk);
    chk("ign_busy", busy16, 1);
    @(negedge clk);
    check16(16'h1234, 16'h0234, 1'b0);
    @(negedge clk);
    chk("ign_single_done", done16, 0);
    chk("ign_no_restart", busy16, 0);

    // back-to-back: start accepted in the DONE cycle
    s16 = 1'b1; a16 = 16'h1234; b16 = 16'h0234; bi16 = 1'b0;
    @(negedge clk);
    s16 = 1'b0;
    repeat (4) @(negedge clk);
    check16(16'h1234, 16'h0234, 1'b0);
    s16 = 1'b1; a16 = 16'h8000; b16 = 16'h0001; bi16 = 1'b0;
    @(negedge clk);
    s16 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("b2b_busy", busy16, 1);
      chk("b2b_nodone", done16, 0);
      @(negedge clk);
    end
    check16(16'h8000, 16'h0001, 1'b0);

    // reset in the second RUN cycle aborts the operation
    @(negedge clk);
    s16 = 1'b1; a16 = 16'h0000; b16 = 16'h0001; bi16 = 1'b0;
    @(negedge clk);
    s16 = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_busy", busy16, 0);
    chk("mid_done", done16, 0);
    chk("mid_diff", d16, 0);
    chk("mid_flags", {bo16, ov16, z16}, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i == 1) rst_n = 1'b1;
      chk("mid_nodone", done16, 0);
    end
    op16(16'h0000, 16'h0001, 1'b0);

    for (int i = 0; i < 10; i++)
      op16(16'($urandom), 16'($urandom), 1'($urandom));

    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      v = 3'(i);
      op1(v[2], v[1], v[0]);
    end

    op8(8'h00, 8'h01, 1'b0);
    op8(8'h80, 8'h01, 1'b0);
    for (int i = 0; i < 10; i++)
      op8(8'($urandom), 8'($urandom), 1'($urandom));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
